// File: rtl/seq_det_frame_ctrl_if.sv
// Frame-request and detector-link signals of the serial "1001" frame sequencer.
// The master issues frames and hosts the detector; the slave is the sequencer.
interface seq_det_frame_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = 4
);
    // start is a request sampled only while the sequencer is idle. A frame is
    // accepted at the edge where start=1 is seen in IDLE. busy marks the frame
    // in progress, and done pulses once with results. Requests seen while busy
    // or done are dropped, not queued.
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             msb_first;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic [IDX_W-1:0] first_pos;
    logic             found;
    logic             det_i;
    logic             det_rst;
    logic             det_z;
    logic [2:0]       dbg_state;

    modport master (
        output start, data_in, msb_first, det_z,
        input  busy, done, match_cnt, first_pos, found, det_i, det_rst, dbg_state
    );

    modport slave (
        input  start, data_in, msb_first, det_z,
        output busy, done, match_cnt, first_pos, found, det_i, det_rst, dbg_state
    );
endinterface

// File: rtl/seq_det_frame_ctrl.sv
// Frame sequencer: clears the "1001" detector, shifts a frame word into it
// serially and reports hit count and index of the first hit.
module seq_det_frame_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int IDX_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    seq_det_frame_ctrl_if.slave  io_bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_bit_cnt;
    logic             r_det_i;
    logic [CNT_W-1:0] r_match_cnt;
    logic [IDX_W-1:0] r_first_pos;
    logic             w_busy;
    logic             w_done;
    logic             w_det_rst;
    logic             w_sample;
    logic [IDX_W-1:0] w_hit_idx;

    // The shift register holds the frame in send order, first bit at the MSB.
    function automatic logic [WIDTH-1:0] f_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.start) w_next_state = S_CLR;
            S_CLR:   w_next_state = S_SHIFT;
            S_SHIFT: if (r_bit_cnt == LAST_IDX) w_next_state = S_DRAIN;
            S_DRAIN: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_det_rst = RST;
        case (r_state)
            S_CLR: begin
                w_busy    = 1'b1;
                w_det_rst = 1'b1;
            end
            S_SHIFT: w_busy = 1'b1;
            S_DRAIN: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // det_z lags the consumed bit by one cycle, so SHIFT k reports bit k-1
    // and DRAIN reports the final bit.
    assign w_sample  = ((r_state == S_SHIFT) && (r_bit_cnt != '0)) || (r_state == S_DRAIN);
    assign w_hit_idx = (r_state == S_DRAIN) ? LAST_IDX : (r_bit_cnt - IDX_W'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_det_i     <= 1'b0;
            r_match_cnt <= '0;
            r_first_pos <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_shift     <= io_bus.msb_first ? io_bus.data_in : f_reverse(io_bus.data_in);
                        r_match_cnt <= '0;
                        r_first_pos <= '0;
                    end
                end
                S_CLR: begin
                    r_det_i   <= r_shift[WIDTH-1];
                    r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                    r_bit_cnt <= '0;
                end
                S_SHIFT: begin
                    if (r_bit_cnt == LAST_IDX) begin
                        r_det_i   <= 1'b0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_det_i   <= r_shift[WIDTH-1];
                        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + IDX_W'(1);
                    end
                end
                default: r_det_i <= 1'b0;
            endcase

            if (w_sample && io_bus.det_z) begin
                if (r_match_cnt == '0) begin
                    r_first_pos <= w_hit_idx;
                end
                if (r_match_cnt != CNT_MAX) begin
                    r_match_cnt <= r_match_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign io_bus.busy      = w_busy;
    assign io_bus.done      = w_done;
    assign io_bus.det_rst   = w_det_rst;
    assign io_bus.det_i     = r_det_i;
    assign io_bus.match_cnt = r_match_cnt;
    assign io_bus.first_pos = r_first_pos;
    assign io_bus.found     = (r_match_cnt != '0);
    assign io_bus.dbg_state = r_state;

endmodule

// File: doc/seq_det_frame_ctrl.md
Name: seq_det_frame_ctrl

Overview:
- Frame sequencer for the serial "1001" sequence-detector datapath.
- Accepts a parallel frame word with a start/busy/done handshake.
- Clears the detector, then shifts the frame into it one bit per clock, MSB- or LSB-first.
- Counts detector hits, records the bit index of the first hit, and reports the results when the frame is finished.

Parameters:
WIDTH, 16, number of bits per frame (2..64)
CNT_W, 5, width of match counter; must satisfy 2^CNT_W > WIDTH
IDX_W, 4, width of bit-index fields; must satisfy 2^IDX_W >= WIDTH

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  request to process data_in; sampled only in IDLE
data_in  in  WIDTH  frame word, captured on the accepting edge
msb_first  in  1  bit order, captured with data_in; 1 = bit WIDTH-1 sent first
busy  out  1  frame in progress
done  out  1  single-cycle pulse: results valid
match_cnt  out  CNT_W  number of detector hits in the last frame
first_pos  out  IDX_W  serial index (0 = first bit sent) of the bit completing the first hit
found  out  1  match_cnt != 0
det_i  out  1  serial bit to the detector
det_rst  out  1  detector clear, active-high
det_z  in  1  detector hit flag; registered in the detector, high for one cycle after the edge that consumed the completing bit

Behaviour:
- Reset (RST high, asynchronous):
  - state = IDLE.
  - busy, done, match_cnt, first_pos, found, det_i = 0.
  - det_rst = 1 while RST is high.
  - Shift register and bit counter cleared.
  - Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - det_rst = 0, det_i = 0.
  - If start = 1 at edge E0: latch data_in and msb_first, clear match_cnt/first_pos/found, go to CLR.
- CLR: one cycle.
  - det_rst = 1, busy = 1.
  - Next state SHIFT, bit index k = 0.
- SHIFT: WIDTH cycles, k = 0..WIDTH-1.
  - det_i = frame bit k: data[WIDTH-1-k] if msb_first, else data[k].
  - det_i is driven from a register and is stable for the whole cycle.
  - busy = 1.
  - After k = WIDTH-1, go to DRAIN.
- DRAIN: one cycle.
  - det_i = 0, busy = 1.
  - Exists only to sample det_z for the last bit.
- Hit sampling:
  - det_z is sampled at the edge ending each cycle from SHIFT k = 1 through DRAIN.
  - A hit sampled at the end of SHIFT cycle k is attributed to bit k-1; a hit sampled at the end of DRAIN is attributed to bit WIDTH-1.
  - On a hit: match_cnt += 1, saturating at 2^CNT_W-1.
  - If this is the first hit: first_pos = attributed index, found = 1.
  - det_z is ignored in IDLE, CLR, DONE and in SHIFT k = 0.
- DONE: one cycle.
  - done = 1, busy = 0.
  - Next state IDLE.
- Results:
  - match_cnt, first_pos, found hold their values until the next accepted start.
  - If there are no hits: first_pos = 0, found = 0.
- Latency:
  - start accepted at edge E0 → done high in the cycle after edge E0+WIDTH+2.
  - busy high for WIDTH+2 cycles.
- Handshake:
  - start while busy or in DONE is ignored; not queued.
  - start held high continuously restarts on the first IDLE cycle, so frames run back-to-back with 1 idle cycle between them.
- Detector overlap:
  - The detector detects overlapping patterns within a frame.
  - The detector is cleared at the start of every frame, so a pattern spanning two frames never counts.
- data_in and msb_first changes after the accepting edge have no effect on the current frame.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, det_rst = 1 only while RST is high.
- WIDTH=16, data_in=16'h9248, msb_first=1, start at E0:
  - Bits sent: 1001001001001000.
  - done in the cycle after E18.
  - match_cnt = 4, first_pos = 3, found = 1.
  - busy high exactly 18 cycles.
- Same data, msb_first=0:
  - Bits sent: 0001001001001001.
  - match_cnt = 4, first_pos = 6.
  - The last hit, at bit 15, is counted via the DRAIN sample.
- Cross-frame isolation:
  - Frame A data_in=16'h0001, msb_first=1 (ends ...0001), then frame B data_in=16'h8000, msb_first=0.
  - Frame A: match_cnt = 0, found = 0.
  - Frame B: bits start 0000... (bit 15 = 1 is sent last) → match_cnt = 0, found = 0.
  - det_rst pulses once per frame, one cycle after the accepting edge.
- Handshake:
  - Pulse start again while busy → ignored, exactly one done.
  - Hold start high → frames restart with one idle cycle between done and the next busy.
- Reset mid-frame:
  - Assert RST at SHIFT k = 7 → busy = 0, match_cnt = 0, no done.
  - After release, a new start with 16'h9248, msb_first=1 yields match_cnt = 4.
